async_fifo_wr_arbiter: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 20 ++
 rtl/fifo_rr_pick.sv | 37 +++
 rtl/async_fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and width helpers for the async FIFO write-side arbiter.
// Holds the FSM state encoding and the source-id / FIFO word width rules.
package async_fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Source-id width: at least one bit even for two requesters.
    function automatic int idw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // FIFO word width: requester data plus the source id on top.
    function automatic int fw_of(input int dw, input int n);
        return dw + idw_of(n);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker.
// Scans from rr_ptr+1 upward (mod N) and returns the first request found.
module fifo_rr_pick
    import async_fifo_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int             j;
    logic [IDW-1:0] jj;

    // First requester after the last winner gets the pick.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        jj   = '0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(rr_ptr) + k) % N;
            jj = IDW'(j);
            if (!any && req[jj]) begin
                pick[jj] = 1'b1;
                idx      = jj;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Packet-level round-robin arbiter in front of the async FIFO write port.
// Each accepted beat is written as {source id, data}.
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int IDW       = idw_of(N_REQ),
    parameter int FW        = DW + IDW
) (
    input  logic                i_wclk,
    input  logic                i_wrstn,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ-1:0]    i_req_last,
    input  logic [N_REQ*DW-1:0] i_req_data,
    output logic [N_REQ-1:0]    o_req_ready,
    output logic                o_fifo_wen,
    output logic [FW-1:0]       o_fifo_wdata,
    input  logic                i_fifo_full,
    output logic [N_REQ-1:0]    o_grant,
    output logic [IDW-1:0]      o_grant_id,
    output logic                o_busy
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] CNT_LAST = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] RR_INIT  = IDW'(N_REQ - 1);

    state_t           state, state_n;
    logic [N_REQ-1:0] grant, grant_n;
    logic [IDW-1:0]   gid, gid_n;
    logic [IDW-1:0]   rr_ptr, rr_n;
    logic [BCW-1:0]   cnt, cnt_n;

    logic [N_REQ-1:0] pick;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    logic [DW-1:0]    data_a [N_REQ];
    logic             busy;
    logic             xfer;
    logic             beat_end;

    for (genvar k = 0; k < N_REQ; k++) begin : g_split
        assign data_a[k] = i_req_data[k*DW +: DW];
    end

    fifo_rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_pick (
        .req    (i_req_valid),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign busy     = (state == BUSY);
    assign xfer     = busy & i_req_valid[gid] & ~i_fifo_full;
    assign beat_end = i_req_last[gid] | (cnt == CNT_LAST);

    assign o_req_ready  = (busy && !i_fifo_full) ? grant : '0;
    assign o_fifo_wen   = xfer;
    assign o_fifo_wdata = xfer ? {gid, data_a[gid]} : '0;
    assign o_grant      = grant;
    assign o_grant_id   = gid;
    assign o_busy       = busy;

    // State, grant, round-robin pointer and beat counter registers.
    always_ff @(posedge i_wclk or negedge i_wrstn) begin
        if (!i_wrstn) begin
            state  <= IDLE;
            grant  <= '0;
            gid    <= '0;
            rr_ptr <= RR_INIT;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            gid    <= gid_n;
            rr_ptr <= rr_n;
            cnt    <= cnt_n;
        end
    end

    // Grant on any request in IDLE; release on last beat or burst cap.
    always_comb begin
        state_n = state;
        grant_n = grant;
        gid_n   = gid;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick;
                    gid_n   = pick_idx;
                    rr_n    = pick_idx;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (beat_end) begin
                        grant_n = '0;
                        gid_n   = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter.
// Packet-level reference model plus per-requester ordering scoreboard.
module tb_async_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int MB  = 8;
    localparam int IDW = 2;
    localparam int FW  = DW + IDW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      valid = '0;
    logic [N-1:0]      last = '0;
    logic [N*DW-1:0]   data = '0;
    logic              full = 1'b0;
    logic [N-1:0]      o_req_ready;
    logic              o_fifo_wen;
    logic [FW-1:0]     o_fifo_wdata;
    logic [N-1:0]      o_grant;
    logic [IDW-1:0]    o_grant_id;
    logic              o_busy;

    always #5 clk = ~clk;

    async_fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .i_wclk       (clk),
        .i_wrstn      (rstn),
        .i_req_valid  (valid),
        .i_req_last   (last),
        .i_req_data   (data),
        .o_req_ready  (o_req_ready),
        .o_fifo_wen   (o_fifo_wen),
        .o_fifo_wdata (o_fifo_wdata),
        .i_fifo_full  (full),
        .o_grant      (o_grant),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] src_q [N][$];
    int          seq_gen [N];
    int          seq_exp [N];
    logic [N-1:0] en = '1;
    logic         full_drv = 1'b0;

    int m_busy = 0;
    int m_g = 0;
    int m_cnt = 0;
    int m_rr = N - 1;
    int cyc = 0;
    int wlog[$];
    int wcyc[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int k, input int len);
        for (int b = 0; b < len; b++) begin
            src_q[k].push_back({(b == len - 1),
                                16'((k << 12) | (seq_gen[k] % 4096))});
            seq_gen[k]++;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && en[k]) begin
                valid[k]         = 1'b1;
                last[k]          = src_q[k][0][16];
                data[k*DW +: DW] = src_q[k][0][15:0];
            end else begin
                valid[k]         = 1'b0;
                last[k]          = 1'b0;
                data[k*DW +: DW] = 16'hdead;
            end
        end
        full = full_drv;
    endtask

    // Compare outputs against the model, then advance the model one clock.
    task automatic eval();
        logic [N-1:0]  eg;
        logic [FW-1:0] ew;
        logic          ex;
        logic [1:0]    g2;
        int            id;
        int            k;
        logic          lst;
        cyc++;
        eg = m_busy ? N'(1 << m_g) : '0;
        g2 = m_g[1:0];
        ex = (m_busy != 0) && valid[m_g] && !full;
        ew = ex ? {g2, data[m_g*DW +: DW]} : '0;
        check("grant", o_grant, eg);
        check("grant_id", o_grant_id, m_busy ? m_g : 0);
        check("busy", o_busy, m_busy);
        check("ready", o_req_ready, (m_busy != 0 && !full) ? eg : '0);
        check("wen", o_fifo_wen, ex);
        check("wdata", o_fifo_wdata, ew);
        check("wen_while_full", o_fifo_wen & full, 0);
        check("grant_onehot", ($countones(o_grant) <= 1), 1);
        if (o_fifo_wen) begin
            id = int'(o_fifo_wdata[FW-1:DW]);
            check("order", o_fifo_wdata[DW-1:0],
                  16'((id << 12) | (seq_exp[id] % 4096)));
            seq_exp[id]++;
            wlog.push_back(id);
            wcyc.push_back(cyc);
        end
        if (m_busy == 0) begin
            for (int j = 1; j <= N; j++) begin
                k = (m_rr + j) % N;
                if (m_busy == 0 && valid[k]) begin
                    m_busy = 1;
                    m_g    = k;
                    m_rr   = k;
                end
            end
        end else if (ex) begin
            lst = src_q[m_g][0][16];
            void'(src_q[m_g].pop_front());
            m_cnt++;
            if (lst || m_cnt == MB) begin
                m_busy = 0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        eval();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    function automatic int pending();
        int p = m_busy;
        for (int k = 0; k < N; k++) p += src_q[k].size();
        return p;
    endfunction

    task automatic drain(input int budget);
        int c = 0;
        while (pending() != 0 && c < budget) begin
            step();
            c++;
        end
        check("drain_timeout", (pending() != 0), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_grant"}, o_grant, 0);
        check({tag, "_grant_id"}, o_grant_id, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_ready"}, o_req_ready, 0);
        check({tag, "_wen"}, o_fifo_wen, 0);
        check({tag, "_wdata"}, o_fifo_wdata, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_zero_outputs("rst_mid");
        @(negedge clk);
        m_busy = 0;
        m_cnt  = 0;
        m_rr   = N - 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        rstn = 1'b1;
        drive();
        eval();
    endtask

    task automatic check_log(input string name, input int base,
                             input int exp_ids[$]);
        check({name, "_len"}, wlog.size() - base, exp_ids.size());
        for (int i = 0; i < exp_ids.size(); i++) begin
            if (base + i < wlog.size())
                check(name, wlog[base + i], exp_ids[i]);
        end
    endtask

    initial begin
        int base;
        int ids[$];
        for (int k = 0; k < N; k++) begin
            seq_gen[k] = 0;
            seq_exp[k] = 0;
        end

        #3 check_zero_outputs("reset");
        @(negedge clk);
        release_reset();

        // Alternating single-beat packets from 0 and 2.
        base = wlog.size();
        add_pkt(0, 1); add_pkt(2, 1); add_pkt(0, 1); add_pkt(2, 1);
        drain(100);
        ids = '{0, 2, 0, 2};
        check_log("alt_ids", base, ids);
        for (int i = 1; i < 4; i++)
            if (base + i < wcyc.size())
                check("alt_bubble", wcyc[base+i] - wcyc[base+i-1], 2);

        // 12-beat packet from 1 split by the burst cap, 3 interleaved.
        base = wlog.size();
        add_pkt(1, 12);
        step();
        add_pkt(3, 1);
        drain(200);
        ids = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 1, 1, 1};
        check_log("burst_ids", base, ids);

        // Full asserted for 5 cycles mid-packet.
        base = wlog.size();
        add_pkt(0, 10);
        step();
        run(2);
        full_drv = 1'b1;
        repeat (5) begin
            step();
            check("full_ready", o_req_ready, 0);
            check("full_wen", o_fifo_wen, 0);
            check("full_grant", o_grant, 4'b0001);
        end
        full_drv = 1'b0;
        drain(200);
        ids = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_log("full_ids", base, ids);
        if (base + 9 < wcyc.size()) begin
            check("full_gap_stall", wcyc[base+2] - wcyc[base+1], 6);
            check("full_gap_cap", wcyc[base+8] - wcyc[base+7], 2);
            check("full_gap_tail", wcyc[base+9] - wcyc[base+8], 1);
        end

        // Requester 2 drops valid mid-packet while 0 waits.
        base = wlog.size();
        add_pkt(2, 5);
        step();
        run(2);
        add_pkt(0, 1);
        en[2] = 1'b0;
        repeat (3) begin
            step();
            check("drop_grant", o_grant, 4'b0100);
            check("drop_wen", o_fifo_wen, 0);
        end
        en = '1;
        drain(200);
        ids = '{2, 2, 2, 2, 2, 0};
        check_log("drop_ids", base, ids);

        // Reset mid-burst, then all four requesters valid.
        add_pkt(1, 8);
        step();
        run(3);
        do_reset();
        add_pkt(0, 1); add_pkt(2, 1); add_pkt(3, 1);
        base = wlog.size();
        release_reset();
        drain(300);
        if (base < wlog.size())
            check("post_reset_first", wlog[base], 0);
        else
            check("post_reset_first_len", wlog.size() - base, 1);

        // Long random run: all requesters backlogged, random full.
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < N; k++)
                if (src_q[k].size() < 3)
                    add_pkt(k, int'($urandom_range(1, 12)));
            full_drv = ($urandom_range(0, 3) == 0);
            step();
        end
        full_drv = 1'b0;
        drain(2000);
        for (int k = 0; k < N; k++)
            check("seq_total", seq_exp[k], seq_gen[k]);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
